// File: rtl/lsu_axil_bridge_pkg.sv
// lsu_axil_bridge_pkg: shared state encoding and AXI4-Lite constants for the LSU bridge.
package lsu_axil_bridge_pkg;

    // One-hot to match the core's control decoding style
    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        RD_ADDR = 6'b000010,
        RD_DATA = 6'b000100,
        WR_REQ  = 6'b001000,
        WR_RESP = 6'b010000,
        DONE    = 6'b100000
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/lsu_axil_bridge_phase_timer.sv
// lsu_axil_bridge_phase_timer: counts cycles spent in one AXI phase, flags when the budget is used up.
module lsu_axil_bridge_phase_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + W'(1);
    end

    assign expired_o = en_i && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/lsu_axil_bridge.sv
// lsu_axil_bridge: turns each core data-memory request into one AXI4-Lite transaction,
// stalling the core until it completes.
module lsu_axil_bridge
    import lsu_axil_bridge_pkg::*;
#(
    parameter int          TIMEOUT   = 256,
    parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_valid_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        m_awvalid_o,
    input  logic        m_awready_i,
    output logic [31:0] m_awaddr_o,
    output logic        m_wvalid_o,
    input  logic        m_wready_i,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    input  logic        m_bvalid_i,
    output logic        m_bready_o,
    input  logic [1:0]  m_bresp_i,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    output logic [31:0] m_araddr_o,
    input  logic        m_rvalid_i,
    output logic        m_rready_o,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i
);

    state_e      state_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, err_q;
    logic        waiting, wr_both, adv, expired;

    assign waiting = state_q inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP};
    // AW and W each count as done once their valid has dropped or is handshaking now
    assign wr_both = (!awvalid_q || m_awready_i) && (!wvalid_q || m_wready_i);
    assign adv = (state_q == IDLE && req_valid_i) || (state_q == RD_ADDR && m_arready_i) ||
                 (state_q == RD_DATA && m_rvalid_i) || (state_q == WR_REQ && wr_both) ||
                 (state_q == WR_RESP && m_bvalid_i) || state_q == DONE || expired;

    lsu_axil_bridge_phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (adv),
        .en_i     (waiting),
        .expired_o(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    addr_q    <= {req_addr_i[31:2], 2'b00};
                    wdata_q   <= req_wdata_i;
                    wstrb_q   <= req_wmask_i;
                    arvalid_q <= !req_wen_i;
                    awvalid_q <= req_wen_i;
                    wvalid_q  <= req_wen_i;
                    state_q   <= req_wen_i ? WR_REQ : RD_ADDR;
                end
                RD_ADDR: if (m_arready_i) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RD_DATA;
                end else if (expired) begin
                    arvalid_q <= 1'b0;
                    rdata_q   <= ERR_RDATA;
                    err_q     <= 1'b1;
                    state_q   <= DONE;
                end
                RD_DATA: if (m_rvalid_i) begin
                    rready_q <= 1'b0;
                    rdata_q  <= m_rdata_i;
                    err_q    <= err_q | (m_rresp_i != RESP_OKAY);
                    state_q  <= DONE;
                end else if (expired) begin
                    rready_q <= 1'b0;
                    rdata_q  <= ERR_RDATA;
                    err_q    <= 1'b1;
                    state_q  <= DONE;
                end
                WR_REQ: begin
                    if (m_awready_i) awvalid_q <= 1'b0;
                    if (m_wready_i) wvalid_q <= 1'b0;
                    if (wr_both) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end else if (expired) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                WR_RESP: if (m_bvalid_i) begin
                    bready_q <= 1'b0;
                    err_q    <= err_q | (m_bresp_i != RESP_OKAY);
                    state_q  <= DONE;
                end else if (expired) begin
                    bready_q <= 1'b0;
                    err_q    <= 1'b1;
                    state_q  <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_valid_o = state_q == DONE;
    assign stall_o     = req_valid_i && state_q != DONE;
    assign err_o       = err_q;
    assign m_awvalid_o = awvalid_q;
    assign m_awaddr_o  = addr_q;
    assign m_wvalid_o  = wvalid_q;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = wstrb_q;
    assign m_bready_o  = bready_q;
    assign m_arvalid_o = arvalid_q;
    assign m_araddr_o  = addr_q;
    assign m_rready_o  = rready_q;

endmodule

// File: tb/tb_lsu_axil_bridge.sv
// tb_lsu_axil_bridge: scoreboard bench for the LSU AXI4-Lite bridge against a
// reactive slave with per-channel latency knobs.
module tb_lsu_axil_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_wen = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wmask = '0;
    logic [31:0] rsp_rdata;
    logic        rsp_valid, stall, err;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    always #5 clk = ~clk;

    lsu_axil_bridge #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_wen_i(req_wen), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .rsp_rdata_o(rsp_rdata), .rsp_valid_o(rsp_valid), .stall_o(stall), .err_o(err),
        .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(m_awaddr),
        .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
        .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .m_bresp_i(m_bresp),
        .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
        .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    logic [31:0] sb[$];

    // Slave knobs (written by the main sequence only)
    int          ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0;
    bit          ar_never = 1'b0;
    logic [31:0] rd_data = '0;
    logic [1:0]  rd_resp = 2'b00;

    // Slave observations (written by the slave only)
    logic [31:0] seen_araddr = '0, seen_awaddr = '0, seen_wdata = '0;
    logic [3:0]  seen_wstrb = '0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, b_rise_cyc = 0, bv_cyc = 0;
    int          wv_cycles = 0, aw_bad = 0, overlap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial forever @(posedge clk) cyc++;

    // Reactive AXI4-Lite slave; evaluates at negedge, handshakes complete at the next posedge
    initial begin
        bit hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0;
        bit r_pend = 0, aw_got = 0, w_got = 0, bready_p = 0;
        int arc = 0, awc = 0, wc = 0, rc = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
                r_pend = 0; aw_got = 0; w_got = 0; bready_p = 0;
                arc = 0; awc = 0; wc = 0; rc = 0;
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
            end else begin
                if (hs_ar) begin r_pend = 1; rc = 0; end
                if (hs_r) m_rvalid = 0;
                if (hs_aw) aw_got = 1;
                if (hs_w) w_got = 1;
                if (hs_b) begin m_bvalid = 0; aw_got = 0; w_got = 0; end
                if (m_awvalid && aw_got) aw_bad++;
                if (m_arvalid && (m_awvalid || m_wvalid)) overlap++;
                if (m_wvalid) wv_cycles++;
                if (m_bready && !bready_p) b_rise_cyc = cyc;
                bready_p = m_bready;
                m_arready = m_arvalid && !ar_never && arc >= ar_lat;
                arc = m_arvalid ? arc + 1 : 0;
                m_awready = m_awvalid && awc >= aw_lat;
                awc = m_awvalid ? awc + 1 : 0;
                m_wready = m_wvalid && wc >= w_lat;
                wc = m_wvalid ? wc + 1 : 0;
                if (r_pend && !m_rvalid) begin
                    if (rc >= r_lat) begin
                        m_rvalid = 1; m_rdata = rd_data; m_rresp = rd_resp; r_pend = 0;
                    end else rc++;
                end
                if (aw_got && w_got && !m_bvalid) begin
                    m_bvalid = 1; m_bresp = 2'b00; bv_cyc = cyc;
                end
                hs_ar = m_arvalid && m_arready;
                hs_aw = m_awvalid && m_awready;
                hs_w  = m_wvalid && m_wready;
                hs_r  = m_rvalid && m_rready;
                hs_b  = m_bvalid && m_bready;
                if (hs_ar) seen_araddr = m_araddr;
                if (hs_aw) begin seen_awaddr = m_awaddr; aw_hs_cyc = cyc; end
                if (hs_w) begin seen_wdata = m_wdata; seen_wstrb = m_wstrb; w_hs_cyc = cyc; end
            end
        end
    end

    int rsp_cyc = 0;

    // Called just after a posedge; returns just after the posedge that ends the DONE cycle
    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [31:0] exp_rdata,
                          output int lat, output int stl, output logic [4:0] v_done);
        bit got = 0;
        sb.push_back(exp_rdata);
        req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask;
        lat = 0; stl = 0; v_done = '0;
        while (!got) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
            else begin
                if (stall) stl++;
                lat++;
                if (lat > 64) begin
                    check("rsp_wait_expired", 32'(lat), 32'd0);
                    break;
                end
            end
        end
        if (got) begin
            rsp_cyc = cyc;
            v_done = {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready};
            check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) check("sb_rdata", rsp_rdata, sb.pop_front());
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, stl, c0, r1, wv0, awb0, ov0;
        logic [4:0] vd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", {24'b0, rsp_valid, stall, err, m_arvalid, m_awvalid, m_wvalid,
                            m_rready, m_bready}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // Zero-wait load with unaligned address
        rd_data = 32'h1122_3344;
        do_req(0, 32'h8000_0006, 32'h0, 4'h0, 32'h1122_3344, lat, stl, vd);
        check("t1_araddr", seen_araddr, 32'h8000_0004);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_stall_cycles", 32'(stl), 32'd3);
        check("t1_err", {31'b0, err}, 32'd0);
        check("t1_idle_at_done", {27'b0, vd}, 32'd0);
        idle();

        // Store with W delayed; load data must stay untouched
        w_lat = 3;
        c0 = cyc; wv0 = wv_cycles; awb0 = aw_bad;
        do_req(1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 32'h1122_3344, lat, stl, vd);
        w_lat = 0;
        check("t2_awaddr", seen_awaddr, 32'h8000_0010);
        check("t2_wdata", seen_wdata, 32'h0000_AB00);
        check("t2_wstrb", {28'b0, seen_wstrb}, 32'h2);
        check("t2_aw_cycle", 32'(aw_hs_cyc - c0), 32'd1);
        check("t2_w_cycle", 32'(w_hs_cyc - c0), 32'd4);
        check("t2_w_held", 32'(wv_cycles - wv0), 32'd4);
        check("t2_aw_dropped", 32'(aw_bad - awb0), 32'd0);
        check("t2_bready_cycle", 32'(b_rise_cyc - c0), 32'd5);
        check("t2_rsp_after_b", 32'(rsp_cyc - bv_cyc), 32'd1);
        check("t2_err", {31'b0, err}, 32'd0);
        idle();

        // Back-to-back load then store, zero-wait
        ov0 = overlap;
        rd_data = 32'hCAFE_0001;
        do_req(0, 32'h0000_0100, 32'h0, 4'h0, 32'hCAFE_0001, lat, stl, vd);
        r1 = rsp_cyc;
        do_req(1, 32'h0000_0104, 32'h1234_5678, 4'hF, 32'hCAFE_0001, lat, stl, vd);
        check("t6_pulse_gap", 32'(rsp_cyc - r1), 32'd4);
        check("t6_store_latency", 32'(lat), 32'd3);
        check("t6_no_overlap", 32'(overlap - ov0), 32'd0);
        check("t6_wdata", seen_wdata, 32'h1234_5678);
        idle();

        // SLVERR on a load: data still returned, err sticky
        rd_data = 32'h5555_5555; rd_resp = 2'b10;
        do_req(0, 32'h0000_0200, 32'h0, 4'h0, 32'h5555_5555, lat, stl, vd);
        rd_resp = 2'b00;
        check("t3_latency", 32'(lat), 32'd3);
        check("t3_err", {31'b0, err}, 32'd1);
        idle();
        rd_data = 32'h0BAD_F00D;
        do_req(0, 32'h0000_0204, 32'h0, 4'h0, 32'h0BAD_F00D, lat, stl, vd);
        check("t3_err_sticky", {31'b0, err}, 32'd1);
        idle();

        // Reset while waiting in RD_DATA
        r_lat = 3; rd_data = 32'h7777_7777;
        req_valid = 1; req_wen = 0; req_addr = 32'h0000_0300;
        repeat (3) @(negedge clk);
        check("t5_rready_pre", {31'b0, m_rready}, 32'd1);
        rst = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_rready", {31'b0, m_rready}, 32'd0);
        check("t5_err", {31'b0, err}, 32'd0);
        check("t5_stall_follows", {31'b0, stall}, 32'd1);
        check("t5_no_rsp", {31'b0, rsp_valid}, 32'd0);
        req_valid = 0;
        #1 check("t5_stall_low", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        rst = 0; r_lat = 0;
        @(posedge clk); #1;
        do_req(1, 32'h0000_0308, 32'hA5A5_A5A5, 4'hC, 32'h0, lat, stl, vd);
        check("t5_post_store_err", {31'b0, err}, 32'd0);
        idle();

        // AR never accepted: forced completion after TIMEOUT cycles in RD_ADDR
        ar_never = 1;
        do_req(0, 32'h0000_0400, 32'h0, 4'h0, 32'hDEAD_BEEF, lat, stl, vd);
        ar_never = 0;
        check("t4_latency", 32'(lat), 32'd9);
        check("t4_valids_done", {27'b0, vd}, 32'd0);
        check("t4_err", {31'b0, err}, 32'd1);
        idle();

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_axil_bridge.md
Name: lsu_axil_bridge

Overview:
Downstream of the single-cycle core's data-memory port. Converts each core data request (enable, write-enable, address, write data, byte mask) into one AXI4-Lite transaction. Holds the core with a stall signal until the transaction completes, then returns the read word. The returned word feeds the core's existing load-data extraction, which does sub-word selection and sign extension.

Parameters:
TIMEOUT, 256, max cycles waiting in any single AXI phase before forced completion with error (must be >=2)
ERR_RDATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
req_valid  in  1  core data request (core dram_en)
req_wen  in  1  1 = store, 0 = load
req_addr  in  32  byte address from core
req_wdata  in  32  lane-aligned store data
req_wmask  in  4  byte-lane strobes for store
rsp_rdata  out  32  read word, valid when rsp_valid=1 for a load
rsp_valid  out  1  one-cycle completion pulse
stall  out  1  core must hold PC and request stable
err  out  1  sticky: any non-OKAY response or timeout since reset
m_awvalid/m_awready/m_awaddr  out/in/out  1/1/32  AXI write address
m_wvalid/m_wready/m_wdata/m_wstrb  out/in/out/out  1/1/32/4  AXI write data
m_bvalid/m_bready/m_bresp  in/out/in  1/1/2  AXI write response
m_arvalid/m_arready/m_araddr  out/in/out  1/1/32  AXI read address
m_rvalid/m_rready/m_rdata/m_rresp  in/out/in/in  1/1/32/2  AXI read data

Behaviour:
- Reset (sync, active-high): state=IDLE; all m_*valid, m_*ready, rsp_valid, err, and the timeout counter = 0; rsp_rdata=0. rst mid-transaction abandons it; the slave shares rst.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE with req_valid:
  - Register addr = {req_addr[31:2],2'b00}, wdata, wstrb.
  - req_wen=0 -> RD_ADDR with m_arvalid=1.
  - req_wen=1 -> WR_REQ with m_awvalid=1 and m_wvalid=1.
- RD_ADDR: m_arvalid stays 1 until m_arready. On handshake -> RD_DATA, m_arvalid=0, m_rready=1.
- RD_DATA: on m_rvalid, capture m_rdata into rsp_rdata; rresp!=00 sets err -> DONE.
- WR_REQ: AW and W are tracked independently. Each valid drops after its own handshake; they may complete in the same cycle or in either order. When both are done -> WR_RESP with m_bready=1.
- WR_RESP: on m_bvalid -> DONE; bresp!=00 sets err. rsp_rdata is unchanged on stores.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE.
- stall = req_valid & (state != DONE), combinational. The core advances in the DONE cycle. A new request is accepted in the following IDLE cycle.
- Best-case latency with zero-wait slave: load = 4 cycles (IDLE, RD_ADDR, RD_DATA, DONE); store = 4 cycles.
- Timeout:
  - Counter clears on every state change and increments otherwise.
  - Reaching TIMEOUT-1 in RD_ADDR/RD_DATA/WR_REQ/WR_RESP forces DONE and sets err. All valids/readies drop. A load returns ERR_RDATA.
- Valids never drop before handshake except on timeout or rst. Address/data/strobe stay stable while valid.
- req_valid dropping mid-transaction is illegal. The bridge still completes, and stall goes low immediately.
- Request inputs are ignored outside IDLE.

Decomposition:
- Shared package holds:
  - the state enum (6 states, one-hot, matching the core's one-hot control style);
  - AXI response constants RESP_OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11;
  - the default ERR_RDATA.
- One natural sub-module: phase_timer (clear, enable, TIMEOUT parameter, expired output), instantiated once.

Test Plan:
- Load addr 0x8000_0006, zero-wait slave returning 0x1122_3344 -> m_araddr=0x8000_0004; stall high 3 cycles; rsp_valid in cycle 3 with rsp_rdata=0x1122_3344; err=0.
- Store addr 0x8000_0010, wdata 0x0000_AB00, wmask 4'b0010; awready in cycle 1, wready delayed to cycle 4 -> AW drops after cycle 1; W held until cycle 4; bready from cycle 5; rsp_valid one cycle after bvalid.
- Load with rresp=2'b10, rdata=0x5555_5555 -> completes normally, rsp_rdata=0x5555_5555, err=1 and stays 1 until rst.
- TIMEOUT=8, arready never asserted -> forced DONE after 8 cycles in RD_ADDR; rsp_rdata=0xDEAD_BEEF; err=1; m_arvalid=0 in DONE.
- rst asserted in RD_DATA -> next cycle state IDLE, m_rready=0, stall follows req_valid, err=0.
- Back-to-back load then store with zero-wait slave -> exactly one IDLE cycle between rsp_valid pulses beyond the 4-cycle latency; no overlapping AR/AW.
